// File: rtl/mopshub_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mopshub_sched_pkg
// Purpose  : Shared types and constants for the mopshub CAN bus scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package mopshub_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_OFFER     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } sched_state_t;

  // Default grant-to-done watchdog budget in clk cycles
  localparam logic [15:0] C_TIMEOUT_CYC_DEFAULT = 16'd4000;

  // Width of the per-bus grant statistics counters
  localparam int C_STAT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational rotate-priority encoder. Returns the lowest set
//            request index at or after i_ptr, wrapping to the lowest set
//            index overall when nothing at/after i_ptr is requesting.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
  parameter int N_BUSES = 32,
  parameter int SEL_W   = $clog2(N_BUSES)
) (
  input  logic [N_BUSES-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [SEL_W-1:0]   o_idx,
  output logic               o_found
);

  logic             w_hit_hi;
  logic             w_hit_lo;
  logic [SEL_W-1:0] w_idx_hi;
  logic [SEL_W-1:0] w_idx_lo;

  // Descending scan: the last hit written is the lowest index in each class
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int k = N_BUSES - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = SEL_W'(k);
        if (k >= int'(i_ptr)) begin
          w_hit_hi = 1'b1;
          w_idx_hi = SEL_W'(k);
        end
      end
    end
    o_found = w_hit_lo;
    o_idx   = w_hit_hi ? w_idx_hi : w_idx_lo;
  end

endmodule
`default_nettype wire

// File: rtl/mopshub_bus_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mopshub_bus_scheduler
// Purpose  : Round-robin scheduler serialising per-bus CAN receive interrupts
//            onto the single uplink path, with runtime masking, a grant
//            watchdog and sticky per-bus timeout flags.
// Options  : MOPSHUB_SCHED_STATS_EN adds per-bus saturating grant counters
//            readable through stat_sel / stat_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module mopshub_bus_scheduler
  import mopshub_sched_pkg::*;
#(
  parameter int                   N_BUSES     = 32,
  parameter int                   SEL_W       = $clog2(N_BUSES),
  parameter int                   TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = TIMEOUT_W'(C_TIMEOUT_CYC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        n_buses,
  input  logic [N_BUSES-1:0]      bus_mask,
  input  logic [N_BUSES-1:0]      irq_can_rec,
  output logic [SEL_W-1:0]        can_rec_select,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  input  logic                    rec_done,
  output logic                    busy,
  output logic                    timeout_pulse,
  output logic [N_BUSES-1:0]      err_bus,
  input  logic                    err_clr
`ifdef MOPSHUB_SCHED_STATS_EN
  ,
  input  logic [SEL_W-1:0]        stat_sel,
  output logic [C_STAT_CNT_W-1:0] stat_cnt
`endif
);

  localparam logic [TIMEOUT_W-1:0] c_wdog_last = TIMEOUT_CYC - TIMEOUT_W'(1);

  sched_state_t           r_state;
  sched_state_t           w_state_nxt;
  logic [SEL_W-1:0]       r_sel;
  logic [SEL_W-1:0]       r_ptr;
  logic [TIMEOUT_W-1:0]   r_wdog;
  logic                   r_timeout;
  logic [N_BUSES-1:0]     r_err;

  logic [N_BUSES-1:0]     w_in_range;
  logic [N_BUSES-1:0]     w_elig;
  logic [SEL_W-1:0]       w_ptr_eff;
  logic [SEL_W-1:0]       w_ptr_rel;
  logic [SEL_W-1:0]       w_pick_idx;
  logic                   w_pick_found;
  logic                   w_load_sel;
  logic                   w_timeout;
  logic [N_BUSES-1:0]     w_err_set;

  genvar gi;
  for (gi = 0; gi < N_BUSES; gi++) begin : g_elig
    assign w_in_range[gi] = (int'(n_buses) >= gi);
  end

  assign w_elig = irq_can_rec & ~bus_mask & ~r_err & w_in_range;

  // A pointer left beyond a shrunken n_buses restarts the search at bus 0
  assign w_ptr_eff = (r_ptr > n_buses) ? '0 : r_ptr;

  // Next search start after a grant, wrapping past the top enabled bus
  assign w_ptr_rel = ((int'(r_sel) >= int'(n_buses)) || (int'(r_sel) >= N_BUSES - 1))
                     ? '0 : r_sel + SEL_W'(1);

  rr_priority_pick #(
    .N_BUSES (N_BUSES),
    .SEL_W   (SEL_W)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (w_ptr_eff),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Next-state and control decode; a transfer beats a same-cycle mask abort
  always_comb begin
    w_state_nxt = r_state;
    w_load_sel  = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = S_OFFER;
          w_load_sel  = 1'b1;
        end
      end
      S_OFFER: begin
        if (rec_ready)           w_state_nxt = S_WAIT_DONE;
        else if (bus_mask[r_sel]) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (rec_done) begin
          w_state_nxt = S_RELEASE;
        end else if (r_wdog == c_wdog_last) begin
          w_state_nxt = S_RELEASE;
          w_timeout   = 1'b1;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_err_set = w_timeout ? ({{(N_BUSES-1){1'b0}}, 1'b1} << r_sel) : '0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Granted bus index, captured on the IDLE pick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_sel <= '0;
    else if (w_load_sel) r_sel <= w_pick_idx;
  end

  // Round-robin pointer advances only once a transfer is finished
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_ptr <= '0;
    else if (r_state == S_RELEASE) r_ptr <= w_ptr_rel;
  end

  // Watchdog counts WAIT_DONE cycles and is held at zero elsewhere
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_wdog <= '0;
    else if (r_state == S_WAIT_DONE) r_wdog <= r_wdog + TIMEOUT_W'(1);
    else                              r_wdog <= '0;
  end

  // One-cycle expiry pulse and sticky error flags; a new error beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout <= 1'b0;
      r_err     <= '0;
    end else begin
      r_timeout <= w_timeout;
      r_err     <= (err_clr ? '0 : r_err) | w_err_set;
    end
  end

  assign can_rec_select = r_sel;
  assign rec_valid      = (r_state == S_OFFER);
  assign busy           = (r_state != S_IDLE);
  assign timeout_pulse  = r_timeout;
  assign err_bus        = r_err;

`ifdef MOPSHUB_SCHED_STATS_EN
  logic [C_STAT_CNT_W-1:0] r_cnt [N_BUSES];
  logic [C_STAT_CNT_W-1:0] r_stat_cnt;
  logic                    w_xfer;

  assign w_xfer = (r_state == S_OFFER) && rec_ready;

  // Per-bus saturating grant counters, cleared together with the error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BUSES; i++) r_cnt[i] <= '0;
    end else if (err_clr) begin
      for (int i = 0; i < N_BUSES; i++) r_cnt[i] <= '0;
    end else if (w_xfer && (r_cnt[r_sel] != '1)) begin
      r_cnt[r_sel] <= r_cnt[r_sel] + C_STAT_CNT_W'(1);
    end
  end

  // Registered counter readout, one clock behind stat_sel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           r_stat_cnt <= '0;
    else if (int'(stat_sel) < N_BUSES) r_stat_cnt <= r_cnt[stat_sel];
    else                                r_stat_cnt <= '0;
  end

  assign stat_cnt = r_stat_cnt;
`endif

endmodule
`default_nettype wire
